time_set_controller: RTL and testbench

TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

---
 rtl/nixie_pkg.sv | 29 ++
 rtl/wrap_counter.sv | 43 ++++
 rtl/time_set_controller.sv | 165 ++++++++++++++++
 tb/tb_time_set_controller.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nixie_pkg.sv
// Shared definitions for the nixie clock time-set logic.
//   state_t          : RUN/EDIT FSM state
//   CUR_SEC/MIN/HR   : one-hot cursor codes for the selected edit field
//   HOURS_MAX/MINSEC_MAX, field widths, timeout counter width
//   cursor_legal()   : true when a cursor code is one of the three one-hot values
package nixie_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_t;

    localparam int CUR_W      = 3;
    localparam int HOURS_W    = 5;
    localparam int MINSEC_W   = 6;
    localparam int TIMEOUT_W  = 6;

    localparam int HOURS_MAX  = 23;
    localparam int MINSEC_MAX = 59;

    localparam logic [CUR_W-1:0] CUR_SEC = 3'b001;
    localparam logic [CUR_W-1:0] CUR_MIN = 3'b010;
    localparam logic [CUR_W-1:0] CUR_HR  = 3'b100;

    function automatic logic cursor_legal(input logic [CUR_W-1:0] c);
        return (c == CUR_SEC) || (c == CUR_MIN) || (c == CUR_HR);
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo (MAX+1) up/down counter used for each time field.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (value -> 0)
//   inc, dec   : step up / down; both together cancel out
//   clear      : synchronous clear to 0
//   value      : current count, always within 0..MAX
//   wrap       : combinational, high when an increment takes MAX back to 0
module wrap_counter #(
    parameter int WIDTH = 6,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

    logic step_up;
    logic step_dn;

    assign step_up = inc && !dec;
    assign step_dn = dec && !inc;
    assign wrap    = step_up && (value == MAXV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value <= '0;
        end else if (clear || (value > MAXV)) begin
            // An out-of-range value is scrubbed before any step is applied
            value <= '0;
        end else if (step_up) begin
            value <= (value == MAXV) ? '0 : value + 1'b1;
        end else if (step_dn) begin
            value <= (value == '0) ? MAXV : value - 1'b1;
        end
    end

endmodule

// File: rtl/time_set_controller.sv
// Time-of-day keeper with a button-driven edit mode.
// RUN: seconds advance on tick1Hz with carries into minutes and hours.
// EDIT: left/right move a one-hot cursor, up/down change the selected field
// without carry; an inactivity timeout (TIMEOUT_S ticks) returns to RUN.
// Ports:
//   clk, reset                         : clock, asynchronous active-high reset
//   tick1Hz                            : once-per-second pulse
//   modePulse                          : toggles RUN/EDIT
//   leftPulse, rightPulse              : cursor moves (EDIT only)
//   upPulse, downPulse                 : field inc/dec (EDIT only)
//   hours, minutes, seconds            : current time, binary
//   cursorPos                          : one-hot selected field (100 h, 010 m, 001 s)
//   editMode, blink                    : EDIT indicator and display blink phase
module time_set_controller
    import nixie_pkg::*;
#(
    parameter int TIMEOUT_S = 30
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick1Hz,
    input  logic                modePulse,
    input  logic                leftPulse,
    input  logic                rightPulse,
    input  logic                upPulse,
    input  logic                downPulse,
    output logic [HOURS_W-1:0]  hours,
    output logic [MINSEC_W-1:0] minutes,
    output logic [MINSEC_W-1:0] seconds,
    output logic [CUR_W-1:0]    cursorPos,
    output logic                editMode,
    output logic                blink
);

    localparam logic [TIMEOUT_W-1:0] TO_LOAD = TIMEOUT_W'(TIMEOUT_S);

    state_t               state;
    logic [TIMEOUT_W-1:0] timeout;

    logic sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
    logic sec_wrap, min_wrap, hr_wrap_unused;
    logic buttons, field_up, field_dn, cur_ok;

    assign buttons  = leftPulse || rightPulse || upPulse || downPulse;
    assign field_up = upPulse && !downPulse;
    assign field_dn = downPulse && !upPulse;
    assign cur_ok   = cursor_legal(cursorPos);

    // Field step requests. RUN chains carries through the wrap outputs; EDIT
    // touches only the selected field, and only when the cursor is legal and
    // no mode toggle is pending.
    always_comb begin
        sec_inc = 1'b0;
        sec_dec = 1'b0;
        min_inc = 1'b0;
        min_dec = 1'b0;
        hr_inc  = 1'b0;
        hr_dec  = 1'b0;
        if (state == ST_RUN) begin
            sec_inc = tick1Hz;
            min_inc = sec_wrap;
            hr_inc  = min_wrap;
        end else if (!modePulse && cur_ok) begin
            sec_inc = field_up && (cursorPos == CUR_SEC);
            sec_dec = field_dn && (cursorPos == CUR_SEC);
            min_inc = field_up && (cursorPos == CUR_MIN);
            min_dec = field_dn && (cursorPos == CUR_MIN);
            hr_inc  = field_up && (cursorPos == CUR_HR);
            hr_dec  = field_dn && (cursorPos == CUR_HR);
        end
    end

    wrap_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (sec_inc),
        .dec   (sec_dec),
        .clear (1'b0),
        .value (seconds),
        .wrap  (sec_wrap)
    );

    wrap_counter #(.WIDTH(MINSEC_W), .MAX(MINSEC_MAX)) u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (min_inc),
        .dec   (min_dec),
        .clear (1'b0),
        .value (minutes),
        .wrap  (min_wrap)
    );

    wrap_counter #(.WIDTH(HOURS_W), .MAX(HOURS_MAX)) u_hr (
        .clk   (clk),
        .reset (reset),
        .inc   (hr_inc),
        .dec   (hr_dec),
        .clear (1'b0),
        .value (hours),
        .wrap  (hr_wrap_unused)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_RUN;
            cursorPos <= CUR_SEC;
            editMode  <= 1'b0;
            blink     <= 1'b0;
            timeout   <= '0;
        end else begin
            // Illegal cursor codes recover to seconds; later assignments in
            // this block only rotate a cursor that is already legal.
            if (!cur_ok) begin
                cursorPos <= CUR_SEC;
            end
            case (state)
                ST_RUN: begin
                    if (modePulse) begin
                        state     <= ST_EDIT;
                        editMode  <= 1'b1;
                        cursorPos <= CUR_SEC;
                        timeout   <= TO_LOAD;
                        blink     <= 1'b1;
                    end else begin
                        editMode  <= 1'b0;
                        blink     <= 1'b0;
                    end
                end
                ST_EDIT: begin
                    if (modePulse) begin
                        state    <= ST_RUN;
                        editMode <= 1'b0;
                        blink    <= 1'b0;
                        timeout  <= '0;
                    end else if (buttons) begin
                        // A button beats a coincident expiring tick
                        timeout <= TO_LOAD;
                        blink   <= 1'b1;
                        if (cur_ok && leftPulse && !rightPulse) begin
                            cursorPos <= {cursorPos[1:0], cursorPos[2]};
                        end else if (cur_ok && rightPulse && !leftPulse) begin
                            cursorPos <= {cursorPos[0], cursorPos[2:1]};
                        end
                    end else if (tick1Hz) begin
                        if ((timeout == '0) || (timeout == TIMEOUT_W'(1))) begin
                            state    <= ST_RUN;
                            editMode <= 1'b0;
                            blink    <= 1'b0;
                            timeout  <= '0;
                        end else begin
                            timeout <= timeout - 1'b1;
                            blink   <= ~blink;
                        end
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    editMode <= 1'b0;
                    blink    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_set_controller.sv
module tb_time_set_controller;

    localparam logic [5:0] P_T = 6'b100000;
    localparam logic [5:0] P_M = 6'b010000;
    localparam logic [5:0] P_L = 6'b001000;
    localparam logic [5:0] P_R = 6'b000100;
    localparam logic [5:0] P_U = 6'b000010;
    localparam logic [5:0] P_D = 6'b000001;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick1Hz, modePulse, leftPulse, rightPulse, upPulse, downPulse;
    logic [4:0] hours;
    logic [5:0] minutes, seconds;
    logic [2:0] cursorPos;
    logic       editMode, blink;
    logic [21:0] obs;

    logic [21:0] exq[$];
    int total = 0;
    int bad   = 0;

    time_set_controller #(.TIMEOUT_S(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick1Hz    (tick1Hz),
        .modePulse  (modePulse),
        .leftPulse  (leftPulse),
        .rightPulse (rightPulse),
        .upPulse    (upPulse),
        .downPulse  (downPulse),
        .hours      (hours),
        .minutes    (minutes),
        .seconds    (seconds),
        .cursorPos  (cursorPos),
        .editMode   (editMode),
        .blink      (blink)
    );

    always #5 clk = ~clk;

    assign obs = {hours, minutes, seconds, cursorPos, editMode, blink};

    function automatic logic [21:0] pk(input int h, input int m, input int s,
                                       input logic [2:0] c, input logic em, input logic bl);
        return {5'(h), 6'(m), 6'(s), c, em, bl};
    endfunction

    function automatic string fmt(input logic [21:0] v);
        return $sformatf("%0d:%0d:%0d cur=%b edit=%b blink=%b",
                         v[21:17], v[16:11], v[10:5], v[4:2], v[1], v[0]);
    endfunction

    // Drive one cycle of pulses and queue the state expected after that edge.
    task automatic step(input logic [5:0] p, input logic [21:0] e);
        @(negedge clk);
        {tick1Hz, modePulse, leftPulse, rightPulse, upPulse, downPulse} = p;
        exq.push_back(e);
        @(posedge clk);
        #1;
        {tick1Hz, modePulse, leftPulse, rightPulse, upPulse, downPulse} = '0;
    endtask

    task automatic test_reset;
        logic [21:0] want;
        reset = 1'b1;
        {tick1Hz, modePulse, leftPulse, rightPulse, upPulse, downPulse} = '0;
        repeat (3) @(posedge clk);
        #1;
        exq.push_back(pk(0, 0, 0, 3'b001, 1'b0, 1'b0));
        want = exq.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL reset_state: got %s want %s", fmt(obs), fmt(want));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rollover;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        ps = '{P_M, P_D, P_D, P_L, P_D, P_L, P_D, P_M, P_T, P_T, P_U | P_L, P_D | P_R};
        es = '{pk(0, 0, 0, 3'b001, 1, 1),   pk(0, 0, 59, 3'b001, 1, 1),
               pk(0, 0, 58, 3'b001, 1, 1),  pk(0, 0, 58, 3'b010, 1, 1),
               pk(0, 59, 58, 3'b010, 1, 1), pk(0, 59, 58, 3'b100, 1, 1),
               pk(23, 59, 58, 3'b100, 1, 1), pk(23, 59, 58, 3'b100, 0, 0),
               pk(23, 59, 59, 3'b100, 0, 0), pk(0, 0, 0, 3'b100, 0, 0),
               pk(0, 0, 0, 3'b100, 0, 0),    pk(0, 0, 0, 3'b100, 0, 0)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL rollover[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    task automatic test_hours_down;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        ps = '{P_M, P_L, P_L, P_D, P_T, P_M};
        es = '{pk(0, 0, 0, 3'b001, 1, 1),  pk(0, 0, 0, 3'b010, 1, 1),
               pk(0, 0, 0, 3'b100, 1, 1),  pk(23, 0, 0, 3'b100, 1, 1),
               pk(23, 0, 0, 3'b100, 1, 0), pk(23, 0, 0, 3'b100, 0, 0)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL hours_down[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    task automatic test_timeout;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        ps = '{P_M, P_T, P_T, P_T, P_T};
        es = '{pk(23, 0, 0, 3'b001, 1, 1), pk(23, 0, 0, 3'b001, 1, 0),
               pk(23, 0, 0, 3'b001, 1, 1), pk(23, 0, 0, 3'b001, 0, 0),
               pk(23, 0, 1, 3'b001, 0, 0)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL timeout[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    // Two ticks after up+down still in EDIT shows the timeout was reloaded.
    task automatic test_simultaneous;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        ps = '{P_M, P_L, P_D, P_T, P_U | P_D, P_T, P_T, P_L | P_R, P_R, P_R, P_R};
        es = '{pk(23, 0, 1, 3'b001, 1, 1),  pk(23, 0, 1, 3'b010, 1, 1),
               pk(23, 59, 1, 3'b010, 1, 1), pk(23, 59, 1, 3'b010, 1, 0),
               pk(23, 59, 1, 3'b010, 1, 1), pk(23, 59, 1, 3'b010, 1, 0),
               pk(23, 59, 1, 3'b010, 1, 1), pk(23, 59, 1, 3'b010, 1, 1),
               pk(23, 59, 1, 3'b001, 1, 1), pk(23, 59, 1, 3'b100, 1, 1),
               pk(23, 59, 1, 3'b010, 1, 1)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL simultaneous[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    task automatic test_expiry_button;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        ps = '{P_T, P_T, P_T | P_U, P_M | P_U};
        es = '{pk(23, 59, 1, 3'b010, 1, 0), pk(23, 59, 1, 3'b010, 1, 1),
               pk(23, 0, 1, 3'b010, 1, 1),  pk(23, 0, 1, 3'b010, 0, 0)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL expiry_button[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    // Presets 12:34:56 starting from 23:00:01, then resets mid-cycle.
    task automatic test_reset_mid_edit;
        logic [5:0]  ps[$];
        logic [21:0] es[$];
        logic [21:0] want;
        int h, m, s;
        h = 23; m = 0; s = 1;
        ps.push_back(P_M); es.push_back(pk(h, m, s, 3'b001, 1, 1));
        for (int k = 0; k < 55; k++) begin
            s = (s + 1) % 60;
            ps.push_back(P_U); es.push_back(pk(h, m, s, 3'b001, 1, 1));
        end
        ps.push_back(P_L); es.push_back(pk(h, m, s, 3'b010, 1, 1));
        for (int k = 0; k < 34; k++) begin
            m = (m + 1) % 60;
            ps.push_back(P_U); es.push_back(pk(h, m, s, 3'b010, 1, 1));
        end
        ps.push_back(P_L); es.push_back(pk(h, m, s, 3'b100, 1, 1));
        for (int k = 0; k < 13; k++) begin
            h = (h + 1) % 24;
            ps.push_back(P_U); es.push_back(pk(h, m, s, 3'b100, 1, 1));
        end
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL preset[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
        want = pk(12, 34, 56, 3'b100, 1, 1);
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL preset_final: got %s want %s", fmt(obs), fmt(want));
        end
        // Assert reset between edges; outputs must clear with no clock edge
        @(negedge clk);
        #2;
        reset = 1'b1;
        exq.push_back(pk(0, 0, 0, 3'b001, 0, 0));
        #1;
        want = exq.pop_front();
        total++;
        if (obs !== want) begin
            bad++;
            $display("FAIL async_reset: got %s want %s", fmt(obs), fmt(want));
        end
        @(negedge clk);
        reset = 1'b0;
        ps = '{P_T, P_U, P_T};
        es = '{pk(0, 0, 1, 3'b001, 0, 0), pk(0, 0, 1, 3'b001, 0, 0),
               pk(0, 0, 2, 3'b001, 0, 0)};
        for (int i = 0; i < ps.size(); i++) begin
            step(ps[i], es[i]);
            want = exq.pop_front();
            total++;
            if (obs !== want) begin
                bad++;
                $display("FAIL post_reset[%0d]: got %s want %s", i, fmt(obs), fmt(want));
            end
        end
    endtask

    initial begin
        test_reset;
        test_rollover;
        test_hours_down;
        test_timeout;
        test_simultaneous;
        test_expiry_button;
        test_reset_mid_edit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
